// File: rtl/kernel_pkg.sv
// Shared definitions for the 7x7 window controller: kernel geometry, FSM states
// and the counter-width helper.
package kernel_pkg;

   localparam int unsigned KSIZE = 7;
   localparam int unsigned KHALF = 3;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFlush,
      StDone
   } state_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster column/row position counter. Advances one pixel per inc_i, wrapping the
// column at the row end and the row at the frame end; clr_i restarts at (0,0).
module raster_counter
   import kernel_pkg::*;
#(
   parameter int unsigned Width  = 8,
   parameter int unsigned Height = 8,
   parameter int unsigned CW     = cnt_width(Width),
   parameter int unsigned RW     = cnt_width(Height)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [CW-1:0] col_o,
   output logic [RW-1:0] row_o,
   output logic          eor_o,
   output logic          lrow_o
);

   localparam logic [CW-1:0] ColLast = CW'(Width - 1);
   localparam logic [RW-1:0] RowLast = RW'(Height - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   assign eor_o  = (col_q == ColLast);
   assign lrow_o = (row_q == RowLast);
   assign col_o  = col_q;
   assign row_o  = row_q;

   // Next position: clear wins over increment; row wraps after the last pixel.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (inc_i) begin
         if (eor_o) begin
            col_d = '0;
            row_d = lrow_o ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Position registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/kernel7_window_ctrl.sv
// Frame sequencer for the 7x7 line-buffer window generator. Accepts a raster
// pixel stream, drives the line-buffer write enable and flags windows lying fully
// inside the image. Optional macro WIN_COORD_EN adds window-centre outputs.
module kernel7_window_ctrl
   import kernel_pkg::*;
#(
   parameter int unsigned IMG_Width  = 8,
   parameter int unsigned IMG_Height = 8,
   parameter int unsigned CW         = cnt_width(IMG_Width),
   parameter int unsigned RW         = cnt_width(IMG_Height)
) (
   input  logic          CLK,
   input  logic          CLR,
   input  logic          Start,
   input  logic          In_Valid,
   output logic          In_Ready,
   output logic          LB_WE,
   output logic          Win_Valid,
   input  logic          Out_Ready,
   output logic          Busy,
   output logic          Frame_Done
`ifdef WIN_COORD_EN
   ,
   output logic [RW-1:0] Win_Row,
   output logic [CW-1:0] Win_Col
`endif
);

   localparam logic [CW-1:0] ColFirst = CW'(KSIZE - 1);
   localparam logic [RW-1:0] RowFirst = RW'(KSIZE - 1);

   state_e        state_q, state_d;
   logic          win_valid_q, win_valid_d;
   logic          cnt_clr, accept, consume, qualify;
   logic          eor, lrow;
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   raster_counter #(
      .Width  (IMG_Width),
      .Height (IMG_Height),
      .CW     (CW),
      .RW     (RW)
   ) u_raster_counter (
      .clk_i  (CLK),
      .rst_ni (CLR),
      .clr_i  (cnt_clr),
      .inc_i  (accept),
      .col_o  (col),
      .row_o  (row),
      .eor_o  (eor),
      .lrow_o (lrow)
   );

   // A held (unconsumed) window blocks new pixels so the line buffer stays frozen.
   assign In_Ready   = (state_q == StRun) && !(win_valid_q && !Out_Ready);
   assign LB_WE      = In_Valid && In_Ready;
   assign accept     = LB_WE;
   assign consume    = win_valid_q && Out_Ready;
   // Columns 0..5 never qualify, which suppresses windows wrapping a row edge.
   assign qualify    = accept && (row >= RowFirst) && (col >= ColFirst);
   assign Win_Valid  = win_valid_q;
   assign Busy       = (state_q != StIdle);
   assign Frame_Done = (state_q == StDone);

   // Frame FSM next-state and counter restart.
   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               cnt_clr = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            if (accept && eor && lrow) state_d = StFlush;
         end
         StFlush: begin
            if (!win_valid_q || Out_Ready) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Window flag: a qualifying accept sets it, a consume without one clears it.
   always_comb begin
      win_valid_d = win_valid_q;
      if (qualify) begin
         win_valid_d = 1'b1;
      end else if (consume) begin
         win_valid_d = 1'b0;
      end
   end

   // FSM state and window flag registers.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q     <= StIdle;
         win_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_valid_q <= win_valid_d;
      end
   end

`ifdef WIN_COORD_EN
   logic [RW-1:0] win_row_q;
   logic [CW-1:0] win_col_q;

   assign Win_Row = win_row_q;
   assign Win_Col = win_col_q;

   // Window centre, captured with each new window and held under stall.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         win_row_q <= '0;
         win_col_q <= '0;
      end else if (qualify) begin
         win_row_q <= row - RW'(KHALF);
         win_col_q <= col - CW'(KHALF);
      end
   end
`endif

endmodule

// File: tb/tb_kernel7_window_ctrl.sv
// Self-checking bench for kernel7_window_ctrl: an 8x8 instance driven from a
// table of frame scenarios plus CLR/reset sequences, and a 10x7 instance.
module tb_kernel7_window_ctrl;

   typedef struct {
      int id;
      int k;
      int r;
      int c;
   } exp_t;

   typedef struct {
      int mode;       // 0: In_Valid held high, 1: toggles every cycle
      int stall;      // Out_Ready low cycles once the first window appears
      int start_mid;  // pulse Start during RUN
      int exp_win;
      int exp_acc;
   } vec_t;

   logic CLK = 1'b0;
   logic CLR;
   logic [1:0] start_v, iv_v, ordy_v;
   logic ir_a, we_a, wv_a, busy_a, fd_a;
   logic ir_b, we_b, wv_b, busy_b, fd_b;
`ifdef WIN_COORD_EN
   logic [2:0] wr_a, wc_a, wr_b;
   logic [3:0] wc_b;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc[2], win[2], fdn[2], last_acc[2], fd_cyc[2];
   bit prev_stall[2];
   int prev_wr[2], prev_wc[2];
   exp_t sb[$];
   vec_t vecs[5];

   always #5 CLK = ~CLK;

   kernel7_window_ctrl #(
      .IMG_Width  (8),
      .IMG_Height (8)
   ) dut_a (
      .CLK        (CLK),
      .CLR        (CLR),
      .Start      (start_v[0]),
      .In_Valid   (iv_v[0]),
      .In_Ready   (ir_a),
      .LB_WE      (we_a),
      .Win_Valid  (wv_a),
      .Out_Ready  (ordy_v[0]),
      .Busy       (busy_a),
      .Frame_Done (fd_a)
`ifdef WIN_COORD_EN
      ,
      .Win_Row    (wr_a),
      .Win_Col    (wc_a)
`endif
   );

   kernel7_window_ctrl #(
      .IMG_Width  (10),
      .IMG_Height (7)
   ) dut_b (
      .CLK        (CLK),
      .CLR        (CLR),
      .Start      (start_v[1]),
      .In_Valid   (iv_v[1]),
      .In_Ready   (ir_b),
      .LB_WE      (we_b),
      .Win_Valid  (wv_b),
      .Out_Ready  (ordy_v[1]),
      .Busy       (busy_b),
      .Frame_Done (fd_b)
`ifdef WIN_COORD_EN
      ,
      .Win_Row    (wr_b),
      .Win_Col    (wc_b)
`endif
   );

   task automatic check(input string name, input int id, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s dut%0d actual=%0d required=%0d at cycle %0d", name, id, act, req, cyc);
      end
   endtask

   // Per-cycle observation of one instance, sampled mid-cycle.
   task automatic monitor(input int id);
      logic st, bsy, iv, ir, we, wv, ordy, fd;
      int w, wr, wc, r, c;
      exp_t e;
      st = start_v[id];
      iv = iv_v[id];
      ordy = ordy_v[id];
      wr = 0;
      wc = 0;
      if (id == 0) begin
         w = 8; bsy = busy_a; ir = ir_a; we = we_a; wv = wv_a; fd = fd_a;
`ifdef WIN_COORD_EN
         wr = int'(wr_a); wc = int'(wc_a);
`endif
      end else begin
         w = 10; bsy = busy_b; ir = ir_b; we = we_b; wv = wv_b; fd = fd_b;
`ifdef WIN_COORD_EN
         wr = int'(wr_b); wc = int'(wc_b);
`endif
      end
      if (st && !bsy) begin
         acc[id] = 0; win[id] = 0; fdn[id] = 0; prev_stall[id] = 1'b0;
         sb.delete();
      end
      check("lb_we", id, int'(we), int'(iv & ir));
      if (!bsy) check("idle_in_ready", id, int'(ir), 0);
      if (prev_stall[id]) begin
         check("stall_hold_valid", id, int'(wv), 1);
`ifdef WIN_COORD_EN
         check("stall_hold_row", id, wr, prev_wr[id]);
         check("stall_hold_col", id, wc, prev_wc[id]);
`endif
      end
      prev_stall[id] = wv && !ordy;
      prev_wr[id] = wr;
      prev_wc[id] = wc;
      if (wv && !ordy) check("stall_in_ready", id, int'(ir), 0);
      if (wv && ordy) begin
         win[id]++;
         check("window_expected", id, int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("window_latency", id, acc[id], e.k);
`ifdef WIN_COORD_EN
            check("centre_row", id, wr, e.r);
            check("centre_col", id, wc, e.c);
`endif
         end
      end
      if (we) begin
         r = acc[id] / w;
         c = acc[id] % w;
         acc[id]++;
         last_acc[id] = cyc;
         if (r >= 6 && c >= 6) begin
            e.id = id; e.k = acc[id]; e.r = r - 3; e.c = c - 3;
            sb.push_back(e);
         end
      end
      if (fd) begin
         fdn[id]++;
         fd_cyc[id] = cyc;
      end
   endtask

   // One clock: observe at the falling edge, then return 1 time unit past the rise.
   task automatic step();
      @(negedge CLK);
      if (CLR) begin
         monitor(0);
         monitor(1);
      end
      @(posedge CLK);
      cyc++;
      #1;
   endtask

   task automatic run_frame(input int id, input vec_t v);
      int stall_left;
      int tail;
      bit stalled;
      logic wv;
      stall_left = 0;
      tail = 0;
      stalled = 1'b0;
      start_v[id] = 1'b1;
      iv_v[id] = 1'b0;
      ordy_v[id] = 1'b1;
      step();
      start_v[id] = 1'b0;
      for (int n = 0; n < 600 && tail < 3; n++) begin
         wv = (id == 0) ? wv_a : wv_b;
         iv_v[id] = (v.mode == 0) ? 1'b1 : 1'((n % 2) == 0);
         if (v.stall > 0 && !stalled && wv) begin
            stalled = 1'b1;
            stall_left = v.stall;
         end
         ordy_v[id] = 1'(stall_left == 0);
         if (stall_left > 0) stall_left--;
         start_v[id] = 1'(v.start_mid != 0 && n == 20);
         step();
         if (fdn[id] > 0) tail++;
      end
      iv_v[id] = 1'b0;
      ordy_v[id] = 1'b1;
      start_v[id] = 1'b0;
      check("windows", id, win[id], v.exp_win);
      check("accepts", id, acc[id], v.exp_acc);
      check("frame_done_pulses", id, fdn[id], 1);
      check("done_latency", id, fd_cyc[id] - last_acc[id], 2);
      check("leftover_windows", id, sb.size(), 0);
      check("busy_after", id, int'((id == 0) ? busy_a : busy_b), 0);
   endtask

   initial begin
      vecs[0] = '{mode: 0, stall: 0, start_mid: 0, exp_win: 4, exp_acc: 64};
      vecs[1] = '{mode: 0, stall: 5, start_mid: 0, exp_win: 4, exp_acc: 64};
      vecs[2] = '{mode: 1, stall: 0, start_mid: 0, exp_win: 4, exp_acc: 64};
      vecs[3] = '{mode: 0, stall: 0, start_mid: 1, exp_win: 4, exp_acc: 64};
      vecs[4] = '{mode: 1, stall: 5, start_mid: 1, exp_win: 4, exp_acc: 64};

      CLR = 1'b0;
      start_v = '0;
      iv_v = '0;
      ordy_v = '0;
      #2;
      check("reset_outputs", 0, int'({ir_a, we_a, wv_a, busy_a, fd_a}), 0);
      check("reset_outputs", 1, int'({ir_b, we_b, wv_b, busy_b, fd_b}), 0);
      start_v = 2'b11;
      iv_v = 2'b11;
      @(posedge CLK);
      #1;
      check("reset_held", 0, int'({ir_a, we_a, wv_a, busy_a, fd_a}), 0);
`ifdef WIN_COORD_EN
      check("reset_coords", 0, int'({wr_a, wc_a}), 0);
`endif
      start_v = '0;
      iv_v = '0;
      ordy_v = 2'b11;
      CLR = 1'b1;
      step();

      for (int i = 0; i < 5; i++) run_frame(0, vecs[i]);

      // Asynchronous clear in the middle of row 4.
      start_v[0] = 1'b1;
      iv_v[0] = 1'b1;
      step();
      start_v[0] = 1'b0;
      repeat (35) step();
      check("pre_clr_accepts", 0, acc[0], 35);
      check("pre_clr_busy", 0, int'(busy_a), 1);
      CLR = 1'b0;
      #1;
      check("clr_outputs", 0, int'({ir_a, we_a, wv_a, busy_a, fd_a}), 0);
      step();
      CLR = 1'b1;
      iv_v[0] = 1'b0;
      step();
      run_frame(0, vecs[0]);

      // 10x7 frame: every window comes from row 6.
      run_frame(1, '{mode: 0, stall: 0, start_mid: 0, exp_win: 4, exp_acc: 70});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
